// File: rtl/cmd_monitor.sv
// Host monitor command interpreter: ping / memory write / memory read over a byte FIFO and UART.
// Optional CMD_MONITOR_CHECKSUM_EN appends an XOR checksum byte to every read response.
module cmd_monitor #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [7:0]            fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_A1,
        GET_A0,
        GET_ARG,
        WRITE,
        RD_ADDR,
        RD_DATA,
        SEND,
        SEND_WAIT
`ifdef CMD_MONITOR_CHECKSUM_EN
        , SEND_CSUM
`endif
    } state_t;

    state_t                state_q;
    logic                  fifo_read_q;
    logic                  transmit_q;
    logic [7:0]            tx_byte_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  mem_write_q;
    logic                  busy_q;
    logic [TW-1:0]         tmo_q;
    logic [8:0]            cnt_q;
    logic [7:0]            a1_q;
    logic [7:0]            resp_q;
    logic                  rd_mode_q;
    logic [1:0]            tx_hold_q;
`ifdef CMD_MONITOR_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic take;
    logic tx_ok;

    // The FIFO head is stale in the cycle fifo_read is high, so it is never sampled then.
    assign take  = !fifo_empty && !fifo_read_q;
    assign tx_ok = !is_transmitting && (tx_hold_q == 2'd0) && !fifo_read_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q     <= IDLE;
            fifo_read_q <= 1'b0;
            transmit_q  <= 1'b0;
            tx_byte_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            a1_q        <= '0;
            resp_q      <= '0;
            rd_mode_q   <= 1'b0;
            tx_hold_q   <= '0;
`ifdef CMD_MONITOR_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            fifo_read_q <= 1'b0;
            transmit_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (tx_hold_q != 2'd0) tx_hold_q <= tx_hold_q - 2'd1;

            case (state_q)
                IDLE: begin
                    if (take) begin
                        fifo_read_q <= 1'b1;
                        busy_q      <= 1'b1;
                        tmo_q       <= '0;
                        case (fifo_data_out)
                            8'h77: begin rd_mode_q <= 1'b0; state_q <= GET_A1; end
                            8'h72: begin rd_mode_q <= 1'b1; state_q <= GET_A1; end
                            8'h70: begin rd_mode_q <= 1'b0; resp_q <= 8'h70; state_q <= SEND; end
                            default: begin rd_mode_q <= 1'b0; resp_q <= 8'h3F; state_q <= SEND; end
                        endcase
                    end
                end

                GET_A1, GET_A0, GET_ARG: begin
                    if (take) begin
                        fifo_read_q <= 1'b1;
                        tmo_q       <= '0;
                        if (state_q == GET_A1) begin
                            a1_q    <= fifo_data_out;
                            state_q <= GET_A0;
                        end else if (state_q == GET_A0) begin
                            mem_addr_q <= ADDR_WIDTH'({a1_q, fifo_data_out});
                            state_q    <= GET_ARG;
                        end else if (rd_mode_q) begin
                            cnt_q   <= (fifo_data_out == 8'h00) ? 9'd256 : {1'b0, fifo_data_out};
`ifdef CMD_MONITOR_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                            state_q <= RD_ADDR;
                        end else begin
                            mem_wdata_q <= fifo_data_out;
                            state_q     <= WRITE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                WRITE: begin
                    mem_write_q <= 1'b1;
                    resp_q      <= 8'h6B;
                    state_q     <= SEND;
                end

                // mem_addr_q already holds the read address, so the RAM samples it this cycle.
                RD_ADDR: state_q <= RD_DATA;

                RD_DATA: begin
                    resp_q  <= mem_rdata;
`ifdef CMD_MONITOR_CHECKSUM_EN
                    csum_q  <= csum_q ^ mem_rdata;
`endif
                    state_q <= SEND;
                end

                SEND: begin
                    if (tx_ok) begin
                        transmit_q <= 1'b1;
                        tx_byte_q  <= resp_q;
                        tx_hold_q  <= 2'd2;
                        if (rd_mode_q) begin
                            state_q <= SEND_WAIT;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                SEND_WAIT: begin
                    cnt_q <= cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
`ifdef CMD_MONITOR_CHECKSUM_EN
                        state_q <= SEND_CSUM;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                        state_q    <= RD_ADDR;
                    end
                end

`ifdef CMD_MONITOR_CHECKSUM_EN
                SEND_CSUM: begin
                    if (tx_ok) begin
                        transmit_q <= 1'b1;
                        tx_byte_q  <= csum_q;
                        tx_hold_q  <= 2'd2;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read = fifo_read_q;
    assign transmit  = transmit_q;
    assign tx_byte   = tx_byte_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cmd_monitor.sv
// Bench for cmd_monitor: FIFO, UART and RAM models plus a command-level scoreboard.
module tb_cmd_monitor;

    localparam int FRAME = 20;
    localparam int TMO   = 100;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  fifo_data_out = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic [7:0]  mem_rdata = '0;
    logic        busy;

    cmd_monitor #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .reset(reset),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_pop = -1000;
    int last_tx  = -1000;
    int tx_cnt   = 0;
    int uart_cnt = 0;
    logic [7:0] prev_tx = '0;
    logic rst_window = 1'b1;

    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_tx [$];
    logic [23:0] exp_wr [$];
    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_write) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Scoreboard and environment models, all evaluated mid-cycle.
    always @(negedge CLK) begin
        if (fifo_read) begin
            check("pop_nonempty", 32'(fifo_q.size() > 0), 1);
            last_pop = cyc;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (transmit) begin
            check("tx_uart_idle", 32'(is_transmitting), 0);
            check("tx_gap", 32'(cyc - last_tx >= 3), 1);
            if (tx_byte == 8'h70) check("ping_latency", 32'(cyc - last_pop >= 2), 1);
            if (exp_tx.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected: got 0x%0h expected no transmit (cycle %0d)", tx_byte, cyc);
            end else begin
                check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
            end
            last_tx = cyc;
            tx_cnt++;
            uart_cnt = FRAME;
        end else if (!rst_window) begin
            check("tx_hold", 32'(tx_byte), 32'(prev_tx));
        end
        prev_tx = tx_byte;
        if (mem_write) begin
            check("wr_latency", 32'(cyc - last_pop), 1);
            if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
            end else begin
                check("wr_addr_data", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_wr.pop_front()});
            end
        end
        if (uart_cnt > 0 && !transmit) uart_cnt--;
        is_transmitting = (uart_cnt > 0);
        fifo_empty = (fifo_q.size() == 0);
        fifo_data_out = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    task automatic put(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic preset(input logic [15:0] a, input logic [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic cmd_simple(input logic [7:0] b);
        put(b);
        exp_tx.push_back((b == 8'h70) ? 8'h70 : 8'h3F);
    endtask

    task automatic cmd_write(input logic [15:0] a, input logic [7:0] d);
        put(8'h77); put(a[15:8]); put(a[7:0]); put(d);
        ref_mem[a] = d;
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h6B);
    endtask

    task automatic cmd_read(input logic [15:0] a, input logic [7:0] n);
        logic [15:0] p;
        logic [7:0]  cs;
        int cnt;
        p = a; cs = '0;
        cnt = (n == 8'h00) ? 256 : int'(n);
        put(8'h72); put(a[15:8]); put(a[7:0]); put(n);
        for (int i = 0; i < cnt; i++) begin
            exp_tx.push_back(ref_mem[p]);
            cs = cs ^ ref_mem[p];
            p = p + 16'd1;
        end
`ifdef CMD_MONITOR_CHECKSUM_EN
        exp_tx.push_back(cs);
`endif
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || fifo_q.size() != 0 || busy) && g < 3000) begin
            @(negedge CLK);
            g++;
        end
        check({name, "_done"}, 32'(g < 3000), 1);
        repeat (4) @(negedge CLK);
        check({name, "_busy"}, 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_fifo_read"}, 32'(fifo_read), 0);
        check({name, "_transmit"}, 32'(transmit), 0);
        check({name, "_tx_byte"}, 32'(tx_byte), 0);
        check({name, "_mem_write"}, 32'(mem_write), 0);
        check({name, "_mem_addr"}, 32'(mem_addr), 0);
        check({name, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({name, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int base;
        int g;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end

        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        rst_window = 1'b0;

        @(posedge CLK); #2;
        cmd_simple(8'h70);
        wait_idle("ping");
        check("ping_byte", 32'(tx_byte), 32'h70);
        check("ping_count", 32'(tx_cnt), 1);

        // A ping queued behind the write must wait in the FIFO until the write completes.
        @(posedge CLK); #2;
        cmd_write(16'h0010, 8'hA5);
        cmd_simple(8'h70);
        wait_idle("write");
        check("ram_0010", 32'(ram[16'h0010]), 32'hA5);
        check("wr_addr_hold", 32'(mem_addr), 32'h0010);
        check("write_count", 32'(tx_cnt), 3);

        @(posedge CLK); #2;
        cmd_simple(8'h78);
        wait_idle("unknown");
        check("unknown_byte", 32'(tx_byte), 32'h3F);

        preset(16'hFFFE, 8'h11);
        preset(16'hFFFF, 8'h22);
        preset(16'h0000, 8'h33);
        base = tx_cnt;
        @(posedge CLK); #2;
        cmd_read(16'hFFFE, 8'h03);
        wait_idle("read_wrap");
`ifdef CMD_MONITOR_CHECKSUM_EN
        check("read_wrap_last", 32'(tx_byte), 32'h00);
        check("read_wrap_count", 32'(tx_cnt - base), 4);
`else
        check("read_wrap_last", 32'(tx_byte), 32'h33);
        check("read_wrap_count", 32'(tx_cnt - base), 3);
`endif

        @(posedge CLK); #2;
        cmd_read(16'h0010, 8'h01);
        wait_idle("read_back");
`ifndef CMD_MONITOR_CHECKSUM_EN
        check("read_back_byte", 32'(tx_byte), 32'hA5);
`endif

        base = tx_cnt;
        @(posedge CLK); #2;
        put(8'h72); put(8'h00);
        repeat (60) @(negedge CLK);
        check("tmo_still_busy", 32'(busy), 1);
        repeat (TMO - 40) @(negedge CLK);
        check("tmo_idle", 32'(busy), 0);
        check("tmo_silent", 32'(tx_cnt - base), 0);
        @(posedge CLK); #2;
        cmd_simple(8'h70);
        wait_idle("tmo_ping");
        check("tmo_ping_byte", 32'(tx_byte), 32'h70);

        for (int i = 0; i < 256; i++) preset(16'(i), 8'(i) ^ 8'h5A);
        base = tx_cnt;
        @(posedge CLK); #2;
        cmd_read(16'h0000, 8'h00);
        g = 0;
        while (tx_cnt < base + 5 && g < 3000) begin
            @(negedge CLK);
            g++;
        end
        check("long_read_5", 32'(tx_cnt - base), 5);
        rst_window = 1'b1;
        reset = 1'b0;
        exp_tx.delete();
        repeat (2) @(negedge CLK);
        check_reset_outputs("midrst");
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        rst_window = 1'b0;
        repeat (80) @(negedge CLK);
        check("midrst_silent", 32'(tx_cnt - base), 5);
        check_reset_outputs("post_rst");

        @(posedge CLK); #2;
        cmd_simple(8'h70);
        wait_idle("recover");
        check("recover_byte", 32'(tx_byte), 32'h70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
